alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand/result width; SHALL match the width of the ALU being driven.
REQ-002 Parameter TAG_WIDTH, default 4, width of the requester transaction tag.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid, index 0/1.
REQ-006 req_ready  output  2  per-requester accept; SHALL be one-hot or zero.
REQ-007 req_op  input  2x4  per-requester opcode.
REQ-008 req_a, req_b  input  2xDATA_WIDTH  per-requester operands.
REQ-009 req_tag  input  2xTAG_WIDTH  per-requester tag.
REQ-010 alu_a, alu_b  output  DATA_WIDTH  operands to the ALU.
REQ-011 alu_ctrl  output  8  ALU control word; alu_cin output 1; alu_out_en output 1.
REQ-012 alu_out  input  DATA_WIDTH; alu_cout input 1  ALU result and carry out.
REQ-013 res_valid output 1; res_ready input 1  result handshake.
REQ-014 res_data output DATA_WIDTH; res_cout output 1; res_tag output TAG_WIDTH; res_src output 1 (granted requester); res_err output 1 (illegal opcode).

Function
REQ-015 Opcodes SHALL be ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5 (~a), ADC=6, SBC=7; 8-15 illegal.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC on grant, EXEC->RESP unconditionally, RESP->IDLE on res_valid&&res_ready.
REQ-017 In IDLE, the arbiter SHALL grant one requester with req_valid high; req_ready SHALL be asserted combinationally only for the granted requester, and only in IDLE.
REQ-018 Arbitration SHALL be round-robin: on a simultaneous request, the requester not granted most recently wins; after reset, requester 0 has priority.
REQ-019 On grant, op, a, b, tag and source SHALL be captured into internal registers.
REQ-020 In EXEC, alu_out_en SHALL be 1, and alu_a/alu_b/alu_ctrl/alu_cin SHALL be driven from the captured request; in all other states alu_out_en, alu_ctrl and alu_cin SHALL be 0, and alu_a/alu_b SHALL hold.
REQ-021 alu_ctrl SHALL come from the package decode table; SUB SHALL use the ALU two's-complement path with alu_cin=0.
REQ-022 At the end of EXEC, alu_out and alu_cout SHALL be registered into res_data/res_cout.
REQ-023 res_valid SHALL be high throughout RESP, with all res_* outputs stable until accepted.
REQ-024 Latency: a request accepted at edge N SHALL produce res_valid at N+2; the next grant SHALL occur no earlier than the edge after the result handshake (maximum one op per 3 cycles with res_ready tied high).
REQ-025 Illegal opcode: ALU SHALL not be enabled in EXEC (alu_out_en=0); res_data=0, res_cout=0, res_err=1; the FSM sequence is unchanged.
REQ-026 res_err SHALL be 0 for legal opcodes.

Reset
REQ-027 On reset: state=IDLE; req_ready=0; alu_a/alu_b=0, alu_ctrl=0, alu_cin=0, alu_out_en=0; res_valid=0 and all res_* outputs=0; RR priority=requester 0; carry flags=0.
REQ-028 Reset asserted during EXEC or RESP SHALL abort the operation; the result SHALL never be presented.

Configuration
REQ-029 Macro ALU_SCHED_CARRY_CHAIN_EN. When defined: one carry flag per requester, updated with alu_cout on every legal ADD/SUB/ADC/SBC from that requester; ADC/SBC SHALL drive alu_cin from the requester's flag.
REQ-030 When the macro is undefined: no carry flags are implemented; ADC SHALL behave exactly as ADD and SBC exactly as SUB.

Structure
REQ-031 Package alu_sched_pkg SHALL hold the opcode enum, the FSM state enum and the opcode->ctrl localparam table.
REQ-032 Sub-module alu_sched_rr_arb (2-input round-robin arbiter, request in, one-hot grant out, priority update on accept) SHALL be used.

Verification
REQ-033 Req0 ADD a=0x0003 b=0x0004 tag=5, res_ready=1 -> res_valid 2 cycles after accept; res_data=0x0007, res_cout=0, res_tag=5, res_src=0.
REQ-034 Both requesters valid continuously, res_ready=1 -> grants alternate 0,1,0,1 starting with 0; one result every 3 cycles.
REQ-035 ADD 0xFFFF+0x0001 then ADC 0x0000+0x0000 from req1 -> results 0x0000/cout=1, then 0x0001 with macro defined; 0x0000 with macro undefined.
REQ-036 res_ready held low 5 cycles in RESP -> res_* stable, req_ready=0 throughout, no new grant.
REQ-037 Opcode 0xC -> res_err=1, res_data=0, alu_out_en never 1.
REQ-038 Reset asserted in EXEC -> all outputs at reset values next cycle; no res_valid afterwards.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and opcode decode for the two-requester ALU scheduler.
package alu_sched_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned CTRL_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_ADC = 4'd6,
        OP_SBC = 4'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // ALU control word: bit0 add, bit1 subtract (two's-complement path), bits2..5 AND/OR/XOR/NOT
    localparam logic [CTRL_W-1:0] OP_CTRL [8] = '{
        8'h01,  // ADD
        8'h03,  // SUB
        8'h04,  // AND
        8'h08,  // OR
        8'h10,  // XOR
        8'h20,  // NOT
        8'h01,  // ADC
        8'h03   // SBC
    };

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return !op[3];
    endfunction

    function automatic logic op_is_arith(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
    endfunction

    function automatic logic op_uses_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Two-input round-robin arbiter; the requester not granted last wins a tie, requester 0 after reset.
module alu_sched_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant_c = 2'b00;
        prio_d  = prio_q;
        if (req == 2'b11) begin
            grant_c = prio_q ? 2'b10 : 2'b01;
        end else begin
            grant_c = req;
        end
        // after granting 0, requester 1 holds priority and vice versa
        if (accept && (grant_c != 2'b00)) begin
            prio_d = grant_c[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Schedules two requesters onto one external ALU (IDLE -> EXEC -> RESP).
// Optional per-requester carry chaining for ADC/SBC under ALU_SCHED_CARRY_CHAIN_EN.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     req_valid,
    output logic [1:0]                     req_ready,
    input  logic [1:0][OP_W-1:0]           req_op,
    input  logic [1:0][DATA_WIDTH-1:0]     req_a,
    input  logic [1:0][DATA_WIDTH-1:0]     req_b,
    input  logic [1:0][TAG_WIDTH-1:0]      req_tag,
    output logic [DATA_WIDTH-1:0]          alu_a,
    output logic [DATA_WIDTH-1:0]          alu_b,
    output logic [CTRL_W-1:0]              alu_ctrl,
    output logic                           alu_cin,
    output logic                           alu_out_en,
    input  logic [DATA_WIDTH-1:0]          alu_out,
    input  logic                           alu_cout,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [DATA_WIDTH-1:0]          res_data,
    output logic                           res_cout,
    output logic [TAG_WIDTH-1:0]           res_tag,
    output logic                           res_src,
    output logic                           res_err
);

    state_e                  state_q, state_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic                    src_q, src_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [CTRL_W-1:0]       alu_ctrl_q, alu_ctrl_d;
    logic                    alu_cin_q, alu_cin_d;
    logic                    alu_out_en_q, alu_out_en_d;
    logic                    res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
    logic                    res_cout_q, res_cout_d;
    logic [TAG_WIDTH-1:0]    res_tag_q, res_tag_d;
    logic                    res_src_q, res_src_d;
    logic                    res_err_q, res_err_d;

    logic [1:0]              arb_req;
    logic [1:0]              grant_c;
    logic                    gidx;
    logic [OP_W-1:0]         g_op;
    logic                    g_cin;

    assign arb_req   = (state_q == ST_IDLE) ? req_valid : 2'b00;
    assign req_ready = grant_c;
    assign gidx      = grant_c[1];
    assign g_op      = req_op[gidx];

    alu_sched_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .accept  (|grant_c),
        .grant_c (grant_c)
    );

`ifdef ALU_SCHED_CARRY_CHAIN_EN
    logic [1:0] carry_q, carry_d;

    assign g_cin = op_uses_carry(g_op) ? carry_q[gidx] : 1'b0;

    // each requester's flag follows the carry of its own legal arithmetic ops
    always_comb begin
        carry_d = carry_q;
        if ((state_q == ST_EXEC) && op_is_arith(op_q)) begin
            carry_d[src_q] = alu_cout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 2'b00;
        end else begin
            carry_q <= carry_d;
        end
    end
`else
    assign g_cin = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        tag_d        = tag_q;
        src_d        = src_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = '0;
        alu_cin_d    = 1'b0;
        alu_out_en_d = 1'b0;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_cout_d   = res_cout_q;
        res_tag_d    = res_tag_q;
        res_src_d    = res_src_q;
        res_err_d    = res_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_c != 2'b00) begin
                    state_d = ST_EXEC;
                    op_d    = g_op;
                    tag_d   = req_tag[gidx];
                    src_d   = gidx;
                    alu_a_d = req_a[gidx];
                    alu_b_d = req_b[gidx];
                    // ALU drive is armed here so it is valid for the whole EXEC cycle
                    if (op_legal(g_op)) begin
                        alu_ctrl_d   = OP_CTRL[g_op[2:0]];
                        alu_cin_d    = g_cin;
                        alu_out_en_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                state_d     = ST_RESP;
                res_valid_d = 1'b1;
                res_tag_d   = tag_q;
                res_src_d   = src_q;
                res_err_d   = !op_legal(op_q);
                res_data_d  = op_legal(op_q) ? alu_out : '0;
                res_cout_d  = op_legal(op_q) ? alu_cout : 1'b0;
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            tag_q        <= '0;
            src_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            alu_cin_q    <= 1'b0;
            alu_out_en_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_cout_q   <= 1'b0;
            res_tag_q    <= '0;
            res_src_q    <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            src_q        <= src_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_cin_q    <= alu_cin_d;
            alu_out_en_q <= alu_out_en_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_cout_q   <= res_cout_d;
            res_tag_q    <= res_tag_d;
            res_src_q    <= res_src_d;
            res_err_q    <= res_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign alu_cin    = alu_cin_q;
    assign alu_out_en = alu_out_en_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_cout   = res_cout_q;
    assign res_tag    = res_tag_q;
    assign res_src    = res_src_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: external ALU behaviour, cycle-level reference model, directed vectors.
module tb_alu_sched;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [1:0][3:0]   req_op = '0;
    logic [1:0][15:0]  req_a = '0;
    logic [1:0][15:0]  req_b = '0;
    logic [1:0][3:0]   req_tag = '0;
    logic [15:0]       alu_a, alu_b, alu_out;
    logic [7:0]        alu_ctrl;
    logic              alu_cin, alu_out_en, alu_cout;
    logic              res_valid, res_ready = 1'b1;
    logic [15:0]       res_data;
    logic              res_cout, res_src, res_err;
    logic [3:0]        res_tag;
    logic [16:0]       alu_sum;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int en_seen = 0;
    int rv_seen = 0;

    alu_sched dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cin(alu_cin),
        .alu_out_en(alu_out_en), .alu_out(alu_out), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_tag(res_tag), .res_src(res_src), .res_err(res_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU: subtract reports a borrow in cout, subtracting cin as a borrow-in
    always_comb begin
        alu_sum = '0;
        if (alu_out_en) begin
            case (alu_ctrl)
                8'h01:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cin);
                8'h03:   alu_sum = {1'b0, alu_a} - {1'b0, alu_b} - 17'(alu_cin);
                8'h04:   alu_sum = {1'b0, alu_a & alu_b};
                8'h08:   alu_sum = {1'b0, alu_a | alu_b};
                8'h10:   alu_sum = {1'b0, alu_a ^ alu_b};
                8'h20:   alu_sum = {1'b0, ~alu_a};
                default: alu_sum = '0;
            endcase
        end
    end
    assign alu_out  = alu_sum[15:0];
    assign alu_cout = alu_sum[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int m_busy = 0, m_last = 1, m_present = 0;
    int m_a, m_b, m_tag, m_src, m_d, m_c, m_e;
    int m_flag [2] = '{0, 0};

    task automatic model_calc(input int op, input int a, input int b, input int src,
                              output int d, output int c, output int e);
        int cin;
        cin = 0;
`ifdef ALU_SCHED_CARRY_CHAIN_EN
        if (op == 6 || op == 7) cin = m_flag[src];
`endif
        d = 0; c = 0; e = 0;
        case (op)
            0, 6: begin d = (a + b + cin) & 'hFFFF; c = ((a + b + cin) > 'hFFFF) ? 1 : 0; end
            1, 7: begin d = (a - b - cin) & 'hFFFF; c = (a < b + cin) ? 1 : 0; end
            2: d = a & b;
            3: d = a | b;
            4: d = a ^ b;
            5: d = (~a) & 'hFFFF;
            default: e = 1;
        endcase
`ifdef ALU_SCHED_CARRY_CHAIN_EN
        if (op <= 1 || op == 6 || op == 7) m_flag[src] = c;
`endif
    endtask

    initial forever begin
        logic [1:0] exp_ready;
        int g;
        bit in_exec, exp_rv;
        @(negedge clk);
        if (alu_out_en) en_seen++;
        if (res_valid) rv_seen++;
        if (reset) begin
            m_busy = 0; m_last = 1; m_flag[0] = 0; m_flag[1] = 0;
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_res_data", 32'(res_data), 0);
            chk("rst_res_misc", {28'(res_tag), res_cout, res_src, res_err}, 0);
            chk("rst_alu_ab", {alu_a, alu_b}, 0);
            chk("rst_alu_ctl", {22'(alu_ctrl), alu_cin, alu_out_en}, 0);
        end else begin
            exp_ready = 2'b00;
            if (m_busy == 0 && req_valid != 2'b00) begin
                if (req_valid == 2'b11) g = (m_last == 0) ? 1 : 0;
                else g = req_valid[1] ? 1 : 0;
                exp_ready[g] = 1'b1;
                m_last = g; m_busy = 1; m_present = cyc + 2; m_src = g;
                m_a = int'(req_a[g]); m_b = int'(req_b[g]); m_tag = int'(req_tag[g]);
                model_calc(int'(req_op[g]), m_a, m_b, g, m_d, m_c, m_e);
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            in_exec = (m_busy != 0) && (cyc == m_present - 1);
            chk("alu_out_en", 32'(alu_out_en), 32'(in_exec && m_e == 0));
            if (in_exec) begin
                chk("alu_a", 32'(alu_a), 32'(m_a));
                chk("alu_b", 32'(alu_b), 32'(m_b));
            end else begin
                chk("alu_ctrl_idle", {23'(alu_ctrl), alu_cin}, 0);
            end
            exp_rv = (m_busy != 0) && (cyc >= m_present);
            chk("res_valid", 32'(res_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("res_data", 32'(res_data), 32'(m_d));
                chk("res_cout", 32'(res_cout), 32'(m_c));
                chk("res_tag", 32'(res_tag), 32'(m_tag));
                chk("res_src", 32'(res_src), 32'(m_src));
                chk("res_err", 32'(res_err), 32'(m_e));
                if (res_ready) m_busy = 0;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic accept_req(input int i, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [3:0] tag, output int acc_cyc);
        bit ok;
        ok = 0; acc_cyc = -1;
        req_op[i] = op; req_a[i] = a; req_b[i] = b; req_tag[i] = tag; req_valid[i] = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin ok = 1; acc_cyc = cyc; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_result(output logic [15:0] d, output logic c, output logic e,
                               output logic [3:0] tg, output logic s, output int rc);
        bit ok;
        ok = 0; rc = -1; d = '0; c = 0; e = 0; tg = '0; s = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1; rc = cyc; d = res_data; c = res_cout; e = res_err; tg = res_tag; s = res_src;
            end
        end
        if (!ok) chk("result_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input int i, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] tag,
                          output logic [15:0] d, output logic c, output logic e);
        int ac, rc;
        logic [3:0] tg;
        logic s;
        accept_req(i, op, a, b, tag, ac);
        wait_result(d, c, e, tg, s, rc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        int ac, rc, en0, ng;
        logic [15:0] d, snap_d;
        logic c, e, s;
        logic [3:0] tg;
        int gidx [8];
        int gcyc [8];
        logic [3:0]  t_op  [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
        logic [15:0] t_a   [4] = '{16'hA5A5, 16'h1200, 16'hF0F0, 16'h00FF};
        logic [15:0] t_b   [4] = '{16'h0FF0, 16'h0034, 16'h0FF0, 16'h1234};
        logic [15:0] t_exp [4] = '{16'h05A0, 16'h1234, 16'hFF00, 16'hFF00};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 0);
        @(posedge clk); #1;

        // single ADD from requester 0: latency and literal result
        accept_req(0, 4'd0, 16'h0003, 16'h0004, 4'd5, ac);
        wait_result(d, c, e, tg, s, rc);
        chk("add_latency", 32'(rc - ac), 2);
        chk("add_data", 32'(d), 32'h0007);
        chk("add_tag_src_cout", {29'(tg), s, c}, {29'd5, 1'b0, 1'b0});

        // carry chain across requesters
        run_op(1, 4'd0, 16'hFFFF, 16'h0001, 4'd3, d, c, e);
        chk("wrap_add", {15'(d), c}, {15'h0000, 1'b1});
        run_op(0, 4'd1, 16'h0007, 16'h0005, 4'd4, d, c, e);
        chk("sub_noborrow", {15'(d), c}, {15'h0002, 1'b0});
        run_op(1, 4'd6, 16'h0000, 16'h0000, 4'd6, d, c, e);
`ifdef ALU_SCHED_CARRY_CHAIN_EN
        chk("adc_chain", 32'(d), 32'h0001);
`else
        chk("adc_chain", 32'(d), 32'h0000);
`endif
        run_op(0, 4'd1, 16'h0005, 16'h0007, 4'd8, d, c, e);
        chk("sub_borrow", {15'(d), c}, {15'hFFFE, 1'b1});
        run_op(0, 4'd7, 16'h0009, 16'h0003, 4'd9, d, c, e);
`ifdef ALU_SCHED_CARRY_CHAIN_EN
        chk("sbc_chain", 32'(d), 32'h0005);
`else
        chk("sbc_chain", 32'(d), 32'h0006);
`endif

        // logic ops alternating requesters
        for (int k = 0; k < 4; k++) begin
            run_op(k % 2, t_op[k], t_a[k], t_b[k], 4'(k), d, c, e);
            chk("logic_op", 32'(d), 32'(t_exp[k]));
        end

        // back-pressure: result held, no grant while stalled
        res_ready = 1'b0;
        accept_req(0, 4'd3, 16'h00F0, 16'h0F00, 4'hA, ac);
        req_op[1] = 4'd0; req_a[1] = 16'h0010; req_b[1] = 16'h0020; req_tag[1] = 4'hB;
        req_valid[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        snap_d = res_data;
        chk("stall_first", 32'(snap_d), 32'h0FF0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(res_valid), 1);
            chk("stall_data", 32'(res_data), 32'(snap_d));
            chk("stall_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        accept_req(1, 4'd0, 16'h0010, 16'h0020, 4'hB, ac);
        wait_result(d, c, e, tg, s, rc);
        chk("after_stall", {27'(d), tg, s}, {27'h0030, 4'hB, 1'b1});

        // illegal opcode
        en0 = en_seen;
        run_op(1, 4'hC, 16'h1111, 16'h2222, 4'd2, d, c, e);
        chk("illegal_err", {30'(d), c, e}, {30'd0, 1'b0, 1'b1});
        chk("illegal_no_en", 32'(en_seen - en0), 0);

        // both requesters continuously valid from reset
        do_reset();
        req_op[0] = 4'd0; req_a[0] = 16'h1234; req_b[0] = 16'h1111; req_tag[0] = 4'd1;
        req_op[1] = 4'd4; req_a[1] = 16'hF0F0; req_b[1] = 16'h0FF0; req_tag[1] = 4'd2;
        req_valid = 2'b11;
        ng = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00 && ng < 8) begin
                gidx[ng] = req_ready[1] ? 1 : 0; gcyc[ng] = cyc; ng++;
            end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        chk("rr_count", 32'(ng), 4);
        for (int k = 0; k < 4 && k < ng; k++) begin
            chk("rr_order", 32'(gidx[k]), 32'(k % 2));
            if (k > 0) chk("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 3);
        end
        repeat (4) @(posedge clk);
        #1;

        // reset during EXEC aborts the operation
        accept_req(0, 4'd0, 16'h0101, 16'h0202, 4'd7, ac);
        chk("abort_exec_en", 32'(alu_out_en), 1);
        reset = 1'b1;
        #1;
        chk("abort_outputs", {alu_out_en, res_valid, 14'(alu_ctrl), alu_a}, 0);
        @(posedge clk); #1 reset = 1'b0;
        rv_seen = 0;
        repeat (8) @(posedge clk);
        chk("abort_no_result", 32'(rv_seen), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
